// File: rtl/adder_pkg.sv
// Shared definitions for the serial adder.
//   state_t    : controller states (IDLE / RUN / DONE)
//   clog2      : ceiling log2, used to size the step counter
//   digit_ok   : legality of a WIDTH / DIGIT pair (DIGIT must divide WIDTH)
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MIN_WIDTH = 2;

  // Ceiling log2 of value; clog2(1) = 0, clog2(9) = 4.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // A configuration is usable when the operand is at least MIN_WIDTH bits
  // and is an exact whole number of DIGIT-bit slices.
  function automatic bit digit_ok(input int width, input int digit);
    return (width >= MIN_WIDTH) && (digit >= 1) && (digit <= width)
           && ((width % digit) == 0);
  endfunction

endpackage

// File: rtl/fa_slice.sv
// Combinational DIGIT-bit ripple-carry adder slice, a chain of 1-bit
// full-adder cells. The serial adder reuses one instance every cycle.
//   a, b     : DIGIT-bit operand digits
//   cin      : carry into bit 0
//   sum      : DIGIT-bit sum digit
//   cout     : carry out of the top bit
//   c_msb_in : carry into the top bit (signed overflow = c_msb_in ^ cout
//              when this slice holds the operand MSB)
module fa_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  // c[i] is the carry into bit i; c[DIGIT] leaves the slice.
  logic [DIGIT:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_cell
    logic p;  // propagate
    assign p        = a[i] ^ b[i];
    assign sum[i]   = p ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & p);
  end

  assign cout     = c[DIGIT];
  assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: adds two WIDTH-bit operands plus carry-in, DIGIT bits
// per clock, LSB first, through one shared fa_slice. Start/busy/done
// handshake; one result every WIDTH/DIGIT + 1 cycles.
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous active-high reset
//   start : request, honoured only while busy = 0 (IDLE or DONE)
//   a, b  : operands, captured on an accepted start
//   cin   : carry-in, captured on an accepted start
//   busy  : high while the digits are being added
//   done  : one-cycle pulse, results updated on the edge entering it
//   sum   : registered WIDTH-bit result (modulo 2^WIDTH)
//   cout  : unsigned carry out of the MSB
//   ovf   : two's-complement overflow
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam bit PARAMS_OK = digit_ok(WIDTH, DIGIT);
  localparam int STEPS     = WIDTH / DIGIT;
  localparam int CNT_W     = clog2(STEPS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  if (!PARAMS_OK) begin : g_bad_params
    $error("serial_adder: DIGIT=%0d must divide WIDTH=%0d (WIDTH >= %0d)",
           DIGIT, WIDTH, MIN_WIDTH);
  end

  // ---------------------------------------------------------------------
  // Control
  // ---------------------------------------------------------------------
  state_t state, state_nxt;
  logic   accept;     // load operands this edge
  logic   last_step;  // current RUN cycle processes the MSB digit

  logic [CNT_W-1:0] cnt;

  assign last_step = (state == RUN) && (cnt == LAST_CNT);

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        // Back-to-back: a start seen during the done cycle is taken at once.
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh;
  logic             carry;

  logic [DIGIT-1:0] s_sum;
  logic             s_cout;
  logic             s_cmsb;

  fa_slice #(.DIGIT(DIGIT)) u_slice (
    .a        (a_sh[DIGIT-1:0]),
    .b        (b_sh[DIGIT-1:0]),
    .cin      (carry),
    .sum      (s_sum),
    .cout     (s_cout),
    .c_msb_in (s_cmsb)
  );

  // New digit enters at the top of the sum register; after STEPS shifts
  // the first (least significant) digit has reached bit 0. Concatenating
  // and slicing stays legal even when DIGIT == WIDTH.
  logic [WIDTH+DIGIT-1:0] sum_cat;
  logic [WIDTH-1:0]       sum_shifted;

  assign sum_cat     = {s_sum, sum_sh};
  assign sum_shifted = sum_cat[WIDTH+DIGIT-1:DIGIT];

  // NOTE: the shift registers, carry and counter are reset alongside the
  // control state so nothing in the datapath can ever carry X.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh   <= a;
      b_sh   <= b;
      sum_sh <= '0;
      carry  <= cin;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sh   <= a_sh >> DIGIT;
      b_sh   <= b_sh >> DIGIT;
      sum_sh <= sum_shifted;
      carry  <= s_cout;
      cnt    <= cnt + 1'b1;
    end
  end

  // Result registers change only on the edge entering DONE, so they hold
  // the previous result through IDLE and RUN. On the last step the slice
  // holds the MSB, so its internal carries give cout and the overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (last_step) begin
      sum  <= sum_shifted;
      cout <= s_cout;
      ovf  <= s_cmsb ^ s_cout;
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder. Four instances cover
// WIDTH/DIGIT = 8/1, 16/4, 8/2 and 12/3. Each instance has a monitor that
// pushes a reference a+b+cin result when a start will be accepted and pops
// and compares it when done pulses. Directed tests cover reset, latency,
// corner operands, input changes while busy, mid-run reset and
// back-to-back starts; a random sweep covers the 8/2 and 12/3 instances.
module tb_serial_adder;

  logic clk;
  logic rst;
  logic [3:0]       start;
  logic [3:0][15:0] a_in;
  logic [3:0][15:0] b_in;
  logic [3:0]       cin_in;

  wire [3:0]        busy_v;
  wire [3:0]        done_v;
  wire [3:0]        cout_v;
  wire [3:0]        ovf_v;
  wire [3:0][15:0]  sum_v;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input int k);
    case (k)
      0: return 8;
      1: return 16;
      2: return 8;
      default: return 12;
    endcase
  endfunction

  function automatic int digit_of(input int k);
    case (k)
      0: return 1;
      1: return 4;
      2: return 2;
      default: return 3;
    endcase
  endfunction

  for (genvar i = 0; i < 4; i++) begin : g_dut
    localparam int W = width_of(i);
    localparam int D = digit_of(i);

    logic [W-1:0] sum_w;
    logic         busy_w, done_w, cout_w, ovf_w;
    logic [W+1:0] exp_q[$];   // {ovf, cout, sum}
    logic [W+1:0] e;
    int           done_cnt = 0;

    serial_adder #(.WIDTH(W), .DIGIT(D)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .start (start[i]),
      .a     (a_in[i][W-1:0]),
      .b     (b_in[i][W-1:0]),
      .cin   (cin_in[i]),
      .busy  (busy_w),
      .done  (done_w),
      .sum   (sum_w),
      .cout  (cout_w),
      .ovf   (ovf_w)
    );

    assign busy_v[i] = busy_w;
    assign done_v[i] = done_w;
    assign cout_v[i] = cout_w;
    assign ovf_v[i]  = ovf_w;
    assign sum_v[i]  = 16'(sum_w);

    function automatic logic [W+1:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic c);
      logic [W:0] f;
      logic       v;
      f = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      v = (x[W-1] == y[W-1]) && (f[W-1] != x[W-1]);
      return {v, f};
    endfunction

    always @(negedge clk) begin
      if (done_w === 1'b1) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check($sformatf("d%0d unexpected done", i), 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("d%0d sum", i),  32'(sum_w), 32'(e[W-1:0]));
          check($sformatf("d%0d cout", i), 32'(cout_w), 32'(e[W]));
          check($sformatf("d%0d ovf", i),  32'(ovf_w), 32'(e[W+1]));
        end
      end
      if (rst) exp_q.delete();
      else if (start[i] && busy_w === 1'b0)
        exp_q.push_back(model(a_in[i][W-1:0], b_in[i][W-1:0], cin_in[i]));
    end
  end

  // Drive one start pulse after the next rising edge; returns 1 ns after
  // the edge that accepted it.
  task automatic start_op(input int k, input logic [15:0] av,
                          input logic [15:0] bv, input logic c);
    @(posedge clk); #1;
    a_in[k]   = av;
    b_in[k]   = bv;
    cin_in[k] = c;
    start[k]  = 1'b1;
    @(posedge clk); #1;
    start[k]  = 1'b0;
  endtask

  // Count negedges until done; done must appear after exp_n cycles with
  // busy high for all exp_n-1 preceding ones and sum held steady meanwhile.
  task automatic wait_done(input int k, input int exp_n, input string tag);
    int          n;
    int          nbusy;
    int          moved;
    logic [15:0] held;
    n     = 0;
    nbusy = 0;
    moved = 0;
    held  = sum_v[k];
    do begin
      @(negedge clk);
      n++;
      if (busy_v[k]) begin
        nbusy++;
        if (sum_v[k] !== held) moved++;
      end
    end while (done_v[k] !== 1'b1 && n < 200);
    check({tag, " latency"}, n, exp_n);
    check({tag, " busy cycles"}, nbusy, exp_n - 1);
    check({tag, " sum stable"}, moved, 0);
  endtask

  task automatic run_rand(input int k);
    logic [15:0] mask;
    logic [15:0] av, bv;
    mask = 16'((32'd1 << width_of(k)) - 1);
    av   = 16'($urandom) & mask;
    bv   = 16'($urandom) & mask;
    start_op(k, av, bv, 1'($urandom));
    wait_done(k, width_of(k) / digit_of(k) + 1, $sformatf("rand d%0d", k));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int dc;
    rst    = 1'b1;
    start  = '0;
    a_in   = '0;
    b_in   = '0;
    cin_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state on every instance.
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("reset busy d%0d", k), 32'(busy_v[k]), 0);
      check($sformatf("reset done d%0d", k), 32'(done_v[k]), 0);
      check($sformatf("reset sum d%0d", k),  32'(sum_v[k]), 0);
      check($sformatf("reset cout d%0d", k), 32'(cout_v[k]), 0);
      check($sformatf("reset ovf d%0d", k),  32'(ovf_v[k]), 0);
    end

    // 0 + 0 + 1, latency 9 at 8/1.
    start_op(0, 16'h00, 16'h00, 1'b1);
    wait_done(0, 9, "zero+cin");
    check("zero+cin sum", 32'(sum_v[0]), 32'h01);

    // Corner operands.
    start_op(0, 16'hFF, 16'h01, 1'b0);
    wait_done(0, 9, "ff+01");
    check("ff+01 sum", 32'(sum_v[0]), 32'h00);
    check("ff+01 cout", 32'(cout_v[0]), 1);
    check("ff+01 ovf", 32'(ovf_v[0]), 0);

    start_op(0, 16'h7F, 16'h01, 1'b0);
    wait_done(0, 9, "7f+01");
    check("7f+01 sum", 32'(sum_v[0]), 32'h80);
    check("7f+01 cout", 32'(cout_v[0]), 0);
    check("7f+01 ovf", 32'(ovf_v[0]), 1);

    start_op(0, 16'h80, 16'h80, 1'b0);
    wait_done(0, 9, "80+80");
    check("80+80 sum", 32'(sum_v[0]), 32'h00);
    check("80+80 cout", 32'(cout_v[0]), 1);
    check("80+80 ovf", 32'(ovf_v[0]), 1);

    // Inputs and start change while busy: no effect, exactly one done.
    start_op(0, 16'h5A, 16'h33, 1'b1);
    dc = g_dut[0].done_cnt;
    repeat (2) @(posedge clk);
    #1;
    a_in[0]   = 16'hC0;
    b_in[0]   = 16'hC0;
    cin_in[0] = 1'b0;
    start[0]  = 1'b1;
    @(posedge clk); #1;
    start[0]  = 1'b0;
    wait_done(0, 6, "busy change");
    check("busy change sum", 32'(sum_v[0]), 32'h8E);
    repeat (12) @(negedge clk);
    check("busy change done count", g_dut[0].done_cnt - dc, 1);
    check("busy change pending", g_dut[0].exp_q.size(), 0);

    // Reset in mid-run: results clear, no done, then a fresh op works.
    start_op(0, 16'h11, 16'h22, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    dc  = g_dut[0].done_cnt;
    @(negedge clk);
    check("mid reset busy", 32'(busy_v[0]), 0);
    check("mid reset sum", 32'(sum_v[0]), 0);
    check("mid reset cout", 32'(cout_v[0]), 0);
    check("mid reset ovf", 32'(ovf_v[0]), 0);
    repeat (12) @(negedge clk);
    check("mid reset no done", g_dut[0].done_cnt - dc, 0);
    start_op(0, 16'h3C, 16'hC3, 1'b1);
    wait_done(0, 9, "after reset");
    check("after reset sum", 32'(sum_v[0]), 32'h00);
    check("after reset cout", 32'(cout_v[0]), 1);

    // 16/4: latency 5, then back-to-back start held through DONE.
    @(posedge clk); #1;
    a_in[1]   = 16'hFFFF;
    b_in[1]   = 16'h0001;
    cin_in[1] = 1'b0;
    start[1]  = 1'b1;
    @(posedge clk); #1;
    a_in[1]   = 16'h1234;
    b_in[1]   = 16'h4321;
    wait_done(1, 5, "w16 first");
    check("w16 first sum", 32'(sum_v[1]), 32'h0000);
    check("w16 first cout", 32'(cout_v[1]), 1);
    check("w16 first ovf", 32'(ovf_v[1]), 0);
    @(posedge clk); #1;
    start[1] = 1'b0;
    wait_done(1, 5, "w16 second");
    check("w16 second sum", 32'(sum_v[1]), 32'h5555);
    check("w16 second cout", 32'(cout_v[1]), 0);

    // Random sweep on 8/2 and 12/3 in parallel.
    fork
      for (int n = 0; n < 1000; n++) run_rand(2);
      for (int n = 0; n < 1000; n++) run_rand(3);
    join

    repeat (4) @(negedge clk);
    check("pending d0", g_dut[0].exp_q.size(), 0);
    check("pending d1", g_dut[1].exp_q.size(), 0);
    check("pending d2", g_dut[2].exp_q.size(), 0);
    check("pending d3", g_dut[3].exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
